// File: rtl/ram_stream_reader.sv
// Streams a run of words out of a synchronous-read single-port RAM onto a
// valid/ready interface, with a 2-entry skid FIFO to absorb the RAM latency.
module ram_stream_reader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_di,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_next_state;
    logic              r_busy;
    logic              r_done;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W:0]   r_iss_cnt;
    logic [ADDR_W:0]   r_out_cnt;
    logic              r_pend;
    logic [DATA_W-1:0] r_fifo [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_occ;
    logic              w_accept;
    logic              w_pop;
    logic              w_issue;
    logic [2:0]        w_level;

    assign w_accept  = (r_state == S_IDLE) && start && (len != '0);
    assign out_valid = (r_occ != 2'd0);
    assign out_data  = r_fifo[r_rd_ptr];
    assign out_last  = out_valid && (r_out_cnt == CNT_ONE);
    assign w_pop     = out_valid && out_ready;
    // Words in flight after this edge; issuing is allowed only if that leaves room for one more.
    assign w_level   = {1'b0, r_occ} + {2'b00, r_pend} - {2'b00, w_pop};
    assign w_issue   = (r_state == S_READ) && (r_iss_cnt != '0) && (w_level <= 3'd1);

    assign busy     = r_busy;
    assign done     = r_done;
    assign mem_we   = 1'b0;
    assign mem_di   = {DATA_W{1'b0}};
    assign mem_addr = r_mem_addr;

    // State register plus registered busy/done flags decoded from the next state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (len == '0) ? S_FIN : S_READ;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_READ: begin
                if (w_issue && (r_iss_cnt == CNT_ONE)) begin
                    w_next_state = S_DRAIN;
                end else begin
                    w_next_state = S_READ;
                end
            end
            S_DRAIN: begin
                if (w_pop && out_last) begin
                    w_next_state = S_FIN;
                end else begin
                    w_next_state = S_DRAIN;
                end
            end
            S_FIN:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode for the state being entered.
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_next_state)
            S_READ:  w_busy_nxt = 1'b1;
            S_DRAIN: w_busy_nxt = 1'b1;
            S_FIN:   w_done_nxt = 1'b1;
            default: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // Address and issue/output counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mem_addr <= '0;
            r_iss_cnt  <= '0;
            r_out_cnt  <= '0;
            r_pend     <= 1'b0;
        end else begin
            r_pend <= w_issue;
            if (w_accept) begin
                r_mem_addr <= base;
                r_iss_cnt  <= len;
                r_out_cnt  <= len;
            end else begin
                if (w_issue) begin
                    r_mem_addr <= r_mem_addr + ADDR_ONE;
                    r_iss_cnt  <= r_iss_cnt - CNT_ONE;
                end
                if (w_pop) begin
                    r_out_cnt <= r_out_cnt - CNT_ONE;
                end
            end
        end
    end

    // Two-entry FIFO: RAM data lands one cycle after its issue.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_occ     <= 2'd0;
        end else begin
            if (r_pend) begin
                r_fifo[r_wr_ptr] <= mem_dout;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({r_pend, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader against a 16-word sync-read RAM model.
module tb_ram_stream_reader;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  base = 4'd0;
    logic [4:0]  len = 5'd0;
    logic        busy, done, mem_we;
    logic [3:0]  mem_addr;
    logic [31:0] mem_di;
    logic [31:0] mem_dout = 32'd0;
    logic        out_valid, out_last;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;

    logic [31:0] ram [16];
    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] cap_data [$];
    logic        cap_last [$];
    int          cap_first_k, cap_done_k, cap_busy_cnt, cap_stable_err, cap_max_ahead;
    logic        cap_busy_at_done, cap_done_after;
    logic [3:0]  cur_base;

    ram_stream_reader #(.ADDR_W(4), .DATA_W(32)) dut (
        .clk(clk), .rstn(rstn), .start(start), .base(base), .len(len),
        .busy(busy), .done(done), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_di(mem_di), .mem_dout(mem_dout), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_dout <= ram[mem_addr];

    task automatic do_start(input logic [3:0] b, input logic [4:0] l);
        start = 1'b1; base = b; len = l; cur_base = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs from the negedge after the accepting edge; k counts those negedges.
    task automatic collect(input int max_cyc, input bit toggle, input int restart_k);
        logic pv, pr, pl;
        logic [31:0] pd;
        logic [3:0] d;
        int hs, ahead;
        cap_data.delete(); cap_last.delete();
        cap_first_k = -1; cap_done_k = -1; cap_busy_cnt = 0; cap_stable_err = 0;
        cap_max_ahead = 0; cap_busy_at_done = 1'b0; cap_done_after = 1'b1;
        pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = 32'd0; hs = 0;
        for (int k = 0; k < max_cyc; k++) begin
            out_ready = toggle ? (k % 2 == 0) : 1'b1;
            if (k == restart_k) begin
                start = 1'b1; base = 4'd8; len = 5'd5;
            end else begin
                start = 1'b0;
            end
            if (pv && !pr && (!out_valid || out_data !== pd || out_last !== pl)) cap_stable_err++;
            d = mem_addr - cur_base;
            ahead = int'(d) - hs;
            if (ahead > cap_max_ahead) cap_max_ahead = ahead;
            if (busy) cap_busy_cnt++;
            if (out_valid && cap_first_k < 0) cap_first_k = k;
            if (out_valid && out_ready) begin
                cap_data.push_back(out_data);
                cap_last.push_back(out_last);
                hs++;
            end
            pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
            if (done) begin
                cap_done_k = k;
                cap_busy_at_done = busy;
                @(negedge clk);
                start = 1'b0;
                cap_done_after = done;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", done); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", out_valid); end
        n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL rst_last got %b want 0", out_last); end
        n_cmp++; if (out_data !== 32'd0) begin n_bad++; $display("FAIL rst_data got %h want 0", out_data); end
        n_cmp++; if (mem_addr !== 4'd0) begin n_bad++; $display("FAIL rst_addr got %h want 0", mem_addr); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_we got %b want 0", mem_we); end
        n_cmp++; if (mem_di !== 32'd0) begin n_bad++; $display("FAIL rst_di got %h want 0", mem_di); end
        rstn = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_idle got busy=%b valid=%b want 0/0", busy, out_valid); end
    endtask

    task automatic test_full_read();
        logic [31:0] e;
        do_start(4'd0, 5'd16);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL full_busy got %b want 1", busy); end
        collect(60, 1'b0, -1);
        n_cmp++; if (cap_first_k !== 2) begin n_bad++; $display("FAIL full_first_valid got %0d want 2", cap_first_k); end
        n_cmp++; if (cap_data.size() !== 16) begin n_bad++; $display("FAIL full_count got %0d want 16", cap_data.size()); end
        for (int i = 0; i < cap_data.size() && i < 16; i++) begin
            e = (i == 15) ? 32'hFFFF_FFFF : 32'(i);
            n_cmp++; if (cap_data[i] !== e) begin n_bad++; $display("FAIL full_word[%0d] got %h want %h", i, cap_data[i], e); end
            n_cmp++; if (cap_last[i] !== (i == 15)) begin n_bad++; $display("FAIL full_last[%0d] got %b want %b", i, cap_last[i], (i == 15)); end
        end
        n_cmp++; if (cap_done_k !== 18) begin n_bad++; $display("FAIL full_done_cycle got %0d want 18", cap_done_k); end
        n_cmp++; if (cap_busy_at_done !== 1'b0) begin n_bad++; $display("FAIL full_busy_at_done got %b want 0", cap_busy_at_done); end
        n_cmp++; if (cap_done_after !== 1'b0) begin n_bad++; $display("FAIL full_done_pulse got %b want 0", cap_done_after); end
    endtask

    task automatic test_wrap();
        logic [31:0] ew [4] = '{32'h0000_000E, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        do_start(4'd14, 5'd4);
        collect(40, 1'b0, -1);
        n_cmp++; if (cap_data.size() !== 4) begin n_bad++; $display("FAIL wrap_count got %0d want 4", cap_data.size()); end
        for (int i = 0; i < cap_data.size() && i < 4; i++) begin
            n_cmp++; if (cap_data[i] !== ew[i]) begin n_bad++; $display("FAIL wrap_word[%0d] got %h want %h", i, cap_data[i], ew[i]); end
            n_cmp++; if (cap_last[i] !== (i == 3)) begin n_bad++; $display("FAIL wrap_last[%0d] got %b want %b", i, cap_last[i], (i == 3)); end
        end
        n_cmp++; if (cap_done_k !== 6) begin n_bad++; $display("FAIL wrap_done_cycle got %0d want 6", cap_done_k); end
    endtask

    task automatic test_stall();
        do_start(4'd2, 5'd5);
        collect(60, 1'b1, -1);
        n_cmp++; if (cap_data.size() !== 5) begin n_bad++; $display("FAIL stall_count got %0d want 5", cap_data.size()); end
        for (int i = 0; i < cap_data.size() && i < 5; i++) begin
            n_cmp++; if (cap_data[i] !== 32'(i + 2)) begin n_bad++; $display("FAIL stall_word[%0d] got %h want %h", i, cap_data[i], i + 2); end
            n_cmp++; if (cap_last[i] !== (i == 4)) begin n_bad++; $display("FAIL stall_last[%0d] got %b want %b", i, cap_last[i], (i == 4)); end
        end
        n_cmp++; if (cap_stable_err !== 0) begin n_bad++; $display("FAIL stall_stable got %0d changes want 0", cap_stable_err); end
        n_cmp++; if (cap_max_ahead > 2) begin n_bad++; $display("FAIL stall_ahead got %0d want <=2", cap_max_ahead); end
        n_cmp++; if (cap_done_k !== 11) begin n_bad++; $display("FAIL stall_done_cycle got %0d want 11", cap_done_k); end
    endtask

    task automatic test_len_zero();
        do_start(4'd3, 5'd0);
        collect(10, 1'b0, -1);
        n_cmp++; if (cap_done_k !== 0) begin n_bad++; $display("FAIL zero_done_cycle got %0d want 0", cap_done_k); end
        n_cmp++; if (cap_first_k !== -1) begin n_bad++; $display("FAIL zero_valid got first at %0d want none", cap_first_k); end
        n_cmp++; if (cap_busy_cnt !== 0) begin n_bad++; $display("FAIL zero_busy got %0d busy cycles want 0", cap_busy_cnt); end
        n_cmp++; if (cap_done_after !== 1'b0) begin n_bad++; $display("FAIL zero_done_pulse got %b want 0", cap_done_after); end
    endtask

    task automatic test_back_to_back();
        do_start(4'd9, 5'd2);
        collect(30, 1'b0, -1);
        n_cmp++; if (cap_data.size() !== 2) begin n_bad++; $display("FAIL b2b_count got %0d want 2", cap_data.size()); end
        if (cap_data.size() == 2) begin
            n_cmp++; if (cap_data[0] !== 32'd9 || cap_data[1] !== 32'd10) begin n_bad++; $display("FAIL b2b_words got %h,%h want 9,a", cap_data[0], cap_data[1]); end
        end
        n_cmp++; if (cap_done_k !== 4) begin n_bad++; $display("FAIL b2b_done_cycle got %0d want 4", cap_done_k); end
    endtask

    task automatic test_start_ignored();
        do_start(4'd0, 5'd3);
        collect(30, 1'b0, 1);
        n_cmp++; if (cap_data.size() !== 3) begin n_bad++; $display("FAIL ign_count got %0d want 3", cap_data.size()); end
        for (int i = 0; i < cap_data.size() && i < 3; i++) begin
            n_cmp++; if (cap_data[i] !== 32'(i)) begin n_bad++; $display("FAIL ign_word[%0d] got %h want %h", i, cap_data[i], i); end
        end
        n_cmp++; if (cap_done_k !== 5) begin n_bad++; $display("FAIL ign_done_cycle got %0d want 5", cap_done_k); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL ign_idle got busy=%b valid=%b want 0/0", busy, out_valid); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        do_start(4'd0, 5'd8);
        out_ready = 1'b1;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            if (out_valid && out_data === 32'd2) seen = 1;
            else @(negedge clk);
        end
        n_cmp++; if (seen !== 1) begin n_bad++; $display("FAIL rmid_word3 got seen=%0d want 1", seen); end
        #2 rstn = 1'b0;
        #1;
        n_cmp++; if ({busy, done, out_valid, out_last} !== 4'b0000) begin n_bad++; $display("FAIL rmid_async_flags got %b want 0000", {busy, done, out_valid, out_last}); end
        n_cmp++; if (out_data !== 32'd0 || mem_addr !== 4'd0) begin n_bad++; $display("FAIL rmid_async_data got %h/%h want 0/0", out_data, mem_addr); end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rmid_hold got done=%b busy=%b want 0/0", done, busy); end
        end
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if ({busy, done, out_valid} !== 3'b000) begin n_bad++; $display("FAIL rmid_idle got %b want 000", {busy, done, out_valid}); end
        end
        do_start(4'd5, 5'd1);
        collect(20, 1'b0, -1);
        n_cmp++; if (cap_data.size() !== 1) begin n_bad++; $display("FAIL rmid_count got %0d want 1", cap_data.size()); end
        if (cap_data.size() == 1) begin
            n_cmp++; if (cap_data[0] !== 32'd5 || cap_last[0] !== 1'b1) begin n_bad++; $display("FAIL rmid_word got %h last=%b want 5 last=1", cap_data[0], cap_last[0]); end
        end
        n_cmp++; if (cap_done_k !== 3) begin n_bad++; $display("FAIL rmid_done_cycle got %0d want 3", cap_done_k); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 32'(i);
        ram[15] = 32'hFFFF_FFFF;
        cur_base = 4'd0;
        @(negedge clk);
        test_reset();
        test_full_read();
        test_wrap();
        test_stall();
        test_len_zero();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
